// File: rtl/memory_adaptor.sv
// Byte-wide RAM/IO bus adaptor serving the instruction fetcher and the load/store unit.
// Each access is split into 1, 2 or 4 little-endian byte transfers; data wins arbitration.
module memory_adaptor #(
    parameter logic [1:0] IO_HI_SEL = 2'b11
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush_pipline,
    input  logic        request_ins_from_memory_adaptor,
    input  logic [31:0] insaddr_to_be_fetched_from_memory_adaptor,
    output logic [31:0] ins_fetched_from_memory_adaptor,
    output logic [1:0]  status_of_memory_adaptor,
    input  logic        data_request,
    input  logic        data_is_write,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [2:0] {IDLE, INS, DREAD, DWRITE, INS_DONE, D_DONE} state_t;

    state_t      state_reg;
    logic [31:0] base_reg;
    logic [31:0] wdata_reg;
    logic [31:0] mem_a_reg;
    logic [31:0] ins_reg;
    logic [31:0] rdata_reg;
    logic [7:0]  dout_reg;
    logic [2:0]  nbytes_reg;
    logic [2:0]  cyc_reg;
    logic        io_sel_reg;
    logic        done_reg;

    logic [2:0]  size_bytes;
    logic [2:0]  cyc_inc;
    logic [1:0]  rd_lane;
    logic [1:0]  wr_lane;
    logic        wr_fire;

    // A write strobe is suppressed combinationally so the IO sink never sees a byte it cannot take.
    assign wr_fire = (state_reg == DWRITE) && rdy_in && !(io_sel_reg && io_buffer_full);
    assign cyc_inc = cyc_reg + 3'd1;
    assign rd_lane = cyc_reg[1:0] - 2'd2;
    assign wr_lane = cyc_inc[1:0];

    always_comb begin
        case (data_size)
            2'd0:    size_bytes = 3'd1;
            2'd1:    size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    end

    always_comb begin
        status_of_memory_adaptor = 2'b00;
        case (state_reg)
            INS:                   status_of_memory_adaptor = 2'b01;
            INS_DONE:              status_of_memory_adaptor = 2'b10;
            DREAD, DWRITE, D_DONE: status_of_memory_adaptor = 2'b11;
            default:               status_of_memory_adaptor = 2'b00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg  <= IDLE;
            base_reg   <= '0;
            wdata_reg  <= '0;
            mem_a_reg  <= '0;
            ins_reg    <= '0;
            rdata_reg  <= '0;
            dout_reg   <= '0;
            nbytes_reg <= '0;
            cyc_reg    <= '0;
            io_sel_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else if (rdy_in) begin
            case (state_reg)
                IDLE: begin
                    done_reg  <= 1'b0;
                    mem_a_reg <= '0;
                    if (data_request) begin
                        base_reg   <= data_addr;
                        wdata_reg  <= data_wdata;
                        nbytes_reg <= size_bytes;
                        io_sel_reg <= (data_addr[17:16] == IO_HI_SEL);
                        mem_a_reg  <= data_addr;
                        if (data_is_write) begin
                            state_reg <= DWRITE;
                            cyc_reg   <= 3'd0;
                            dout_reg  <= data_wdata[7:0];
                        end else begin
                            state_reg <= DREAD;
                            cyc_reg   <= 3'd1;
                            rdata_reg <= '0;
                        end
                    end else if (request_ins_from_memory_adaptor && !flush_pipline) begin
                        state_reg  <= INS;
                        base_reg   <= insaddr_to_be_fetched_from_memory_adaptor;
                        nbytes_reg <= 3'd4;
                        cyc_reg    <= 3'd1;
                        mem_a_reg  <= insaddr_to_be_fetched_from_memory_adaptor;
                    end
                end
                INS, DREAD: begin
                    if (state_reg == INS && flush_pipline) begin
                        state_reg <= IDLE;
                        mem_a_reg <= '0;
                    end else begin
                        // cyc_reg counts cycles since acceptance; the byte on mem_din lags its address by one.
                        if (cyc_reg >= 3'd2) begin
                            if (state_reg == INS)
                                ins_reg[{rd_lane, 3'b000} +: 8] <= mem_din;
                            else
                                rdata_reg[{rd_lane, 3'b000} +: 8] <= mem_din;
                        end
                        mem_a_reg <= (cyc_reg < nbytes_reg) ? base_reg + {29'd0, cyc_reg} : '0;
                        if (cyc_reg == nbytes_reg + 3'd1) begin
                            state_reg <= (state_reg == INS) ? INS_DONE : D_DONE;
                            done_reg  <= (state_reg == DREAD);
                        end
                        cyc_reg <= cyc_inc;
                    end
                end
                DWRITE: begin
                    if (wr_fire) begin
                        if (cyc_inc < nbytes_reg) begin
                            cyc_reg   <= cyc_inc;
                            mem_a_reg <= base_reg + {29'd0, cyc_inc};
                            dout_reg  <= wdata_reg[{wr_lane, 3'b000} +: 8];
                        end else begin
                            state_reg <= D_DONE;
                            done_reg  <= 1'b1;
                            mem_a_reg <= '0;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    done_reg  <= 1'b0;
                    mem_a_reg <= '0;
                end
            endcase
        end
    end

    assign ins_fetched_from_memory_adaptor = ins_reg;
    assign data_rdata = rdata_reg;
    assign data_done  = done_reg;
    assign mem_a      = mem_a_reg;
    assign mem_dout   = dout_reg;
    assign mem_wr     = wr_fire;

endmodule
